// File: rtl/sbox_lane_pipe_if.sv
// Valid/ready request and response bundle for the AES byte-substitution pipe.
interface sbox_lane_pipe_if #(
  parameter int unsigned LANES = 4,
  parameter int unsigned TAG_W = 4
) ();
  localparam int unsigned DATA_W = 8 * LANES;

  logic              in_valid;
  logic              in_ready;
  logic              in_inv;
  logic [DATA_W-1:0] in_data;
  logic [TAG_W-1:0]  in_tag;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_inv;
  logic [TAG_W-1:0]  out_tag;

  // Producer/consumer side: drives requests, flush and downstream ready.
  modport master (
    output in_valid, in_inv, in_data, in_tag, flush, out_ready,
    input  in_ready, out_valid, out_data, out_inv, out_tag
  );

  // Substitution unit side.
  modport slave (
    input  in_valid, in_inv, in_data, in_tag, flush, out_ready,
    output in_ready, out_valid, out_data, out_inv, out_tag
  );
endinterface

// File: rtl/sbox_lane_pipe.sv
// Two-stage pipelined AES SubBytes / InvSubBytes over LANES parallel bytes.
// S1 registers the request, the S-box lookup sits between S1 and S2,
// S2 drives the result. Valid/ready on both sides, one transfer per cycle.
module sbox_lane_pipe #(
  parameter int unsigned LANES = 4,
  parameter int unsigned TAG_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  sbox_lane_pipe_if.slave bus
);
  localparam int unsigned DATA_W = 8 * LANES;

  // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = a;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  // Forward affine map applied after inversion.
  function automatic logic [7:0] aff_fwd(input logic [7:0] a);
    return a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]}
             ^ {a[3:0], a[7:4]} ^ 8'h63;
  endfunction

  // Inverse affine map applied before inversion.
  function automatic logic [7:0] aff_inv(input logic [7:0] b);
    return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
  endfunction

  logic              r_s1_valid;
  logic              r_s1_inv;
  logic [DATA_W-1:0] r_s1_data;
  logic [TAG_W-1:0]  r_s1_tag;
  logic              r_s2_valid;
  logic              r_s2_inv;
  logic [DATA_W-1:0] r_s2_data;
  logic [TAG_W-1:0]  r_s2_tag;

  logic              w_s2_adv;
  logic              w_s1_adv;
  logic              w_accept;
  logic [DATA_W-1:0] w_sub;

  // Each stage advances when empty or when the stage after it drains.
  assign w_s2_adv     = !r_s2_valid || bus.out_ready;
  assign w_s1_adv     = !r_s1_valid || w_s2_adv;
  assign bus.in_ready = w_s1_adv && !bus.flush;
  assign w_accept     = bus.in_valid && bus.in_ready;

  // Per-lane substitution of the S1 contents, direction chosen by the stored inv bit.
  always_comb begin
    w_sub = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      w_sub[8*k +: 8] = r_s1_inv ? gf_inv(aff_inv(r_s1_data[8*k +: 8]))
                                 : aff_fwd(gf_inv(r_s1_data[8*k +: 8]));
    end
  end

  // Stage 1: capture the accepted request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_inv   <= 1'b0;
      r_s1_data  <= '0;
      r_s1_tag   <= '0;
    end else if (bus.flush) begin
      r_s1_valid <= 1'b0;
    end else if (w_s1_adv) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_inv  <= bus.in_inv;
        r_s1_data <= bus.in_data;
        r_s1_tag  <= bus.in_tag;
      end
    end
  end

  // Stage 2: capture the lookup result; holds while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_inv   <= 1'b0;
      r_s2_data  <= '0;
      r_s2_tag   <= '0;
    end else if (bus.flush) begin
      r_s2_valid <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_inv  <= r_s1_inv;
        r_s2_data <= w_sub;
        r_s2_tag  <= r_s1_tag;
      end
    end
  end

  assign bus.out_valid = r_s2_valid;
  assign bus.out_inv   = r_s2_inv;
  assign bus.out_data  = r_s2_data;
  assign bus.out_tag   = r_s2_tag;

endmodule

// File: tb/tb_sbox_lane_pipe.sv
// Scoreboard bench for sbox_lane_pipe: the driver queues expected results at
// each accept, a negedge monitor pops and compares on every output transfer.
module tb_sbox_lane_pipe;
  localparam int unsigned LANES = 4;
  localparam int unsigned TAG_W = 4;

  typedef struct packed {
    logic [31:0] d;
    logic        inv;
    logic [3:0]  tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sbox_lane_pipe_if #(.LANES(LANES), .TAG_W(TAG_W)) bus ();

  sbox_lane_pipe #(.LANES(LANES), .TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int n_out = 0;
  exp_t exp_q[$];
  logic [7:0]    fwd_tab[256];
  logic [2047:0] sbox_v;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s act=%0h req=%0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] fwd_model(input logic [31:0] d);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = fwd_tab[d[8*k +: 8]];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one transaction; push its expected result at the cycle it is accepted.
  task automatic send(input logic [31:0] d, input logic inv, input logic [3:0] tag,
                      input logic [31:0] exp_d, output int waits);
    bit done;
    done  = 1'b0;
    waits = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_inv   = inv;
    bus.in_tag   = tag;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        exp_q.push_back('{d: exp_d, inv: inv, tag: tag});
        done = 1'b1;
      end else begin
        waits++;
      end
      @(posedge clk);
      #1;
    end
    if (!done) check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 100 && exp_q.size() != 0; c++) tick();
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: every output transfer must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      n_out++;
      if (exp_q.size() == 0) begin
        check("unexpected_out", {32'd0, bus.out_data}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_data", 64'(bus.out_data), 64'(e.d));
        check("sb_inv",  64'(bus.out_inv),  64'(e.inv));
        check("sb_tag",  64'(bus.out_tag),  64'(e.tag));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    int stall_total;
    int start_out;
    logic [31:0] d;

    sbox_v = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
    for (int i = 0; i < 256; i++) fwd_tab[i] = sbox_v[2047-8*i -: 8];

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_inv    = 1'b0;
    bus.in_tag    = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    #12;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data",  64'(bus.out_data),  64'd0);
    check("rst_out_inv",   64'(bus.out_inv),   64'd0);
    check("rst_out_tag",   64'(bus.out_tag),   64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    tick();

    // Forward vector with 2-cycle latency
    send(32'hFF53_0100, 1'b0, 4'd3, 32'h16ED_7C63, w);
    idle();
    @(negedge clk);
    check("lat_early", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    check("lat_2", 64'(bus.out_valid), 64'd1);
    check("fwd_vec", 64'(bus.out_data), 64'h16ED_7C63);
    tick();
    tick();

    // Inverse vector
    send(32'h1600_7C63, 1'b1, 4'd4, 32'hFF52_0100, w);
    idle();
    @(negedge clk);
    @(negedge clk);
    check("inv_vec", 64'(bus.out_data), 64'hFF52_0100);
    check("inv_vec_inv", 64'(bus.out_inv), 64'd1);
    tick();
    tick();

    // All 256 bytes forward, then inverse of those results back to identity
    stall_total = 0;
    start_out   = n_out;
    for (int k = 0; k < 64; k++) begin
      d = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
      send(d, 1'b0, 4'(k), fwd_model(d), w);
      stall_total += w;
    end
    for (int k = 0; k < 64; k++) begin
      d = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
      send(fwd_model(d), 1'b1, 4'(k), d, w);
      stall_total += w;
    end
    idle();
    tick();
    tick();
    tick();
    check("stream_stalls", 64'(stall_total), 64'd0);
    check("stream_count", 64'(n_out - start_out), 64'd128);

    // Backpressure: six transactions, output stalled from the third cycle
    fork
      begin
        int wb;
        for (int t = 0; t < 6; t++) begin
          send({4{8'(16*t+1)}}, 1'b0, 4'(t), fwd_model({4{8'(16*t+1)}}), wb);
        end
        idle();
      end
      begin
        logic [31:0] ref_d;
        tick();
        tick();
        tick();
        bus.out_ready = 1'b0;
        @(negedge clk);
        ref_d = bus.out_data;
        check("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
        check("bp_valid", 64'(bus.out_valid), 64'd1);
        check("bp_held_tag", 64'(bus.out_tag), 64'd1);
        for (int c = 0; c < 4; c++) begin
          @(negedge clk);
          check("bp_data_stable", 64'(bus.out_data), 64'(ref_d));
          check("bp_in_ready_held", 64'(bus.in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          check("bp_no_gap", 64'(bus.out_valid), 64'd1);
        end
      end
    join
    tick();
    wait_drain();

    // Alternating direction on an all-zero input, no bubbles
    stall_total = 0;
    for (int i = 0; i < 8; i++) begin
      send(32'h0000_0000, 1'(i), 4'(i), (i % 2 == 1) ? 32'h5252_5252 : 32'h6363_6363, w);
      stall_total += w;
    end
    idle();
    check("alt_stalls", 64'(stall_total), 64'd0);
    wait_drain();

    // Flush with two in flight and a request offered in the flush cycle
    bus.out_ready = 1'b0;
    send(32'h0011_2233, 1'b0, 4'hA, fwd_model(32'h0011_2233), w);
    send(32'h4455_6677, 1'b0, 4'hB, fwd_model(32'h4455_6677), w);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hDEAD_BEEF;
    bus.in_tag   = 4'hC;
    bus.flush    = 1'b1;
    @(negedge clk);
    check("flush_in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    #1;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("flush_out_valid", 64'(bus.out_valid), 64'd0);
    bus.out_ready = 1'b1;
    tick();
    send(32'h0A0B_0C0D, 1'b0, 4'hD, 32'h672B_FED7, w);
    idle();
    @(negedge clk);
    @(negedge clk);
    check("flush_after_data", 64'(bus.out_data), 64'h672B_FED7);
    check("flush_after_tag", 64'(bus.out_tag), 64'hD);
    tick();
    wait_drain();
    tick();
    tick();
    check("flush_no_extra", 64'(bus.out_valid), 64'd0);

    // Asynchronous reset between clock edges while a result is held
    bus.out_ready = 1'b0;
    send(32'h5353_5353, 1'b0, 4'h7, 32'hEDED_EDED, w);
    idle();
    @(negedge clk);
    @(negedge clk);
    check("ar_valid_before", 64'(bus.out_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("ar_out_valid", 64'(bus.out_valid), 64'd0);
    check("ar_out_data",  64'(bus.out_data),  64'd0);
    check("ar_out_tag",   64'(bus.out_tag),   64'd0);
    check("ar_out_inv",   64'(bus.out_inv),   64'd0);
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check("ar_in_ready", 64'(bus.in_ready), 64'd1);
    tick();
    send(32'h0000_0001, 1'b0, 4'h9, 32'h6363_637C, w);
    idle();
    @(negedge clk);
    @(negedge clk);
    check("ar_resume", 64'(bus.out_data), 64'h6363_637C);
    tick();
    wait_drain();

    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
